// File: rtl/shifter_planar_packer.sv
// Packs one colour index per accepted pixel into Atari ST interleaved bitplane words
// and emits the planes of each completed 16-pixel group over a valid/ready handshake.
module shifter_planar_packer (
    input  logic        clk32,
    input  logic        nReset,
    input  logic        pixClkEn,
    input  logic        DE,
    input  logic [1:0]  rez,
    input  logic [3:0]  color_index,
    input  logic        ovf_clr,
    output logic [15:0] dout,
    output logic [1:0]  dout_plane,
    output logic        dout_last,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        overflow
);

    logic [15:0] acc_q  [4];
    logic [15:0] acc_d  [4];
    logic [15:0] hold_q [4];
    logic [3:0]  pcnt_q;
    logic [1:0]  grez_q;
    logic [1:0]  nlast_q;
    logic [1:0]  widx_q;
    logic [15:0] dout_q;
    logic [1:0]  plane_q;
    logic        last_q;
    logic        valid_q;
    logic        ovf_q;

    logic        accept_s;
    logic        abort_s;
    logic        complete_s;
    logic        hs_s;
    logic        bank_free_s;
    logic [1:0]  grp_nlast_s;
    logic [1:0]  widx_nx_s;

    // Shifted plane words and the handshake / group-completion decode.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            acc_d[p] = {acc_q[p][14:0], color_index[p]};
        end
        accept_s    = pixClkEn & DE;
        abort_s     = pixClkEn & ~DE & (pcnt_q != 4'd0);
        complete_s  = accept_s & (pcnt_q == 4'd15);
        hs_s        = valid_q & dout_ready;
        // A bank whose final word hands off on this edge can take the new group.
        bank_free_s = ~valid_q | (hs_s & last_q);
        widx_nx_s   = widx_q + 2'd1;
        case (grez_q)
            2'b00:   grp_nlast_s = 2'd3;
            2'b01:   grp_nlast_s = 2'd1;
            default: grp_nlast_s = 2'd0;
        endcase
    end

    // Accumulator, pixel counter and group resolution latch.
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            for (int p = 0; p < 4; p++) begin
                acc_q[p] <= 16'h0000;
            end
            pcnt_q <= 4'd0;
            grez_q <= 2'b00;
        end else if (accept_s) begin
            for (int p = 0; p < 4; p++) begin
                acc_q[p] <= acc_d[p];
            end
            pcnt_q <= pcnt_q + 4'd1;
            if (pcnt_q == 4'd0) begin
                grez_q <= rez;
            end
        end else if (abort_s) begin
            pcnt_q <= 4'd0;
        end
    end

    // Holding bank and registered output word sequencing.
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            for (int p = 0; p < 4; p++) begin
                hold_q[p] <= 16'h0000;
            end
            nlast_q <= 2'd0;
            widx_q  <= 2'd0;
            dout_q  <= 16'h0000;
            plane_q <= 2'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (complete_s && bank_free_s) begin
            for (int p = 0; p < 4; p++) begin
                hold_q[p] <= acc_d[p];
            end
            nlast_q <= grp_nlast_s;
            widx_q  <= 2'd0;
            dout_q  <= acc_d[0];
            plane_q <= 2'd0;
            last_q  <= (grp_nlast_s == 2'd0);
            valid_q <= 1'b1;
        end else if (hs_s) begin
            if (last_q) begin
                widx_q  <= 2'd0;
                valid_q <= 1'b0;
            end else begin
                widx_q  <= widx_nx_s;
                dout_q  <= hold_q[widx_nx_s];
                plane_q <= widx_nx_s;
                last_q  <= (widx_nx_s == nlast_q);
            end
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            ovf_q <= 1'b0;
        end else if (complete_s && !bank_free_s) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_plane = plane_q;
    assign dout_last  = last_q;
    assign dout_valid = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/shifter_planar_packer.md
# shifter_planar_packer

Inverse of the ST shifter video path. Accepts one colour index per pixel clock enable and packs pixels into Atari ST interleaved bitplane words: 4 planes in low rez, 2 in mid, 1 in high. Packed words are emitted MSB-first-pixel through a valid/ready handshake to a memory writer, so the block can capture or regenerate frame data for the video path. The block sits on clk32 beside the shifter and feeds a DMA/write port.

## Interface
Parameters: none.

Ports:
- clk32  in  1  system clock; all state changes on posedge.
- nReset  in  1  reset, asynchronous, active-low.
- pixClkEn  in  1  pixel clock enable; one pixel is sampled per enabled cycle while DE=1.
- DE  in  1  display enable; pixels are accepted only when pixClkEn & DE.
- rez  in  2  resolution: 00 low (4 planes), 01 mid (2 planes), 1x high (1 plane).
- color_index  in  4  pixel colour; bit p goes to plane p.
- ovf_clr  in  1  synchronous clear of the overflow flag.
- dout  out  16  packed plane word.
- dout_plane  out  2  plane number of dout.
- dout_last  out  1  dout is the final word of its 16-pixel group.
- dout_valid  out  1  dout/dout_plane/dout_last are valid.
- dout_ready  in  1  consumer accepts the word on the clk32 edge where valid & ready.
- overflow  out  1  sticky flag: a completed group was dropped.

## Operation
- Accumulator: four 16-bit shift registers acc[0..3] and a 4-bit pixel counter pcnt.
  - On each accepted pixel, every acc[p] <= {acc[p][14:0], color_index[p]} and pcnt increments.
  - The pixel accepted at pcnt=n lands at bit 15-n of each plane word.
- Group rez: rez is latched into grez on the pixel accepted at pcnt=0 and held for the whole group. A rez change mid-group has no effect until the next group. Plane count NP = 4/2/1 for grez 00/01/1x. Unused planes are still shifted but never emitted.
- DE abort: pixClkEn & ~DE with pcnt≠0 discards the partial group and sets pcnt to 0. Nothing is emitted and overflow is not set.
- Group completion: the pixel accepted at pcnt=15 completes the group and pcnt wraps to 0.
  - If the holding bank is free, the 4 final plane words (including the last pixel) and NP are copied into the holding bank.
  - If the holding bank is busy, the group is dropped and overflow is set.
- Holding bank emits words in order plane 0, 1, …, NP-1.
  - dout = hold[widx], dout_plane = widx, dout_last = (widx == NP-1).
  - widx advances on each valid & ready edge. After the last word the bank is free.
- Simultaneous events:
  - If the last handshake of the bank and a group completion fall on the same edge, the bank counts as free. The new group loads, dout_valid stays 1, widx becomes 0, and no overflow is set.
  - If ovf_clr and a new overflow fall on the same edge, overflow stays 1 (set wins).
- Output stability: while dout_valid & ~dout_ready, dout, dout_plane and dout_last must not change.

## Timing
- Reset values (asynchronous, immediate on nReset low):
  - dout=0, dout_plane=0, dout_last=0, dout_valid=0, overflow=0.
  - acc=0, pcnt=0, widx=0, grez=00, bank free.
- Reset mid-group or mid-emission discards all data. After release, accumulation starts at the next accepted pixel at pcnt=0.
- Latency: dout_valid rises on the clk32 edge that accepts the 16th pixel. The first word is visible in the following cycle.
- Throughput: one word per clk32 when dout_ready=1. A 4-word group drains in 4 cycles, far below the 16-pixel period at any pixClkEn rate.
- dout_valid falls on the edge of the last handshake unless a new group loads on that same edge.
- All outputs are registered; no combinational path from dout_ready to any output.

## Test plan
- Low rez, ready=1: 16 pixels color_index=0..15 with pixClkEn every 4th cycle and DE=1 -> four words 0x5555, 0x3333, 0x0F0F, 0x00FF. dout_plane 0..3, dout_last only on 0x00FF, then dout_valid=0.
- Mid rez, same stimulus -> exactly two words 0x5555, 0x3333 with dout_last on the second. In high rez, pixels alternating 1,0 -> one word 0xAAAA with last=1.
- Backpressure: low rez, ready=0 for 80 cycles across two complete groups -> the first group stays held (0x5555 stable) and the second is dropped with overflow=1. Release ready -> only the first group's 4 words appear. Pulse ovf_clr -> overflow=0.
- Boundary: hold ready=0 so the bank is still full when the next group completes, with the 4th word's handshake on the same edge as the 16th pixel of the next group -> no overflow. The next group's plane 0 is presented with valid held high.
- DE abort: 7 pixels, then DE=0 for one pixClkEn, then 16 pixels of index 0xF -> one group 0xFFFF×4 and no output from the aborted pixels. A rez change from 00 to 10 at pixel 8 has no effect on that group.
- Reset: assert nReset during emission of word 2 -> all outputs 0 immediately. After release, a fresh 16-pixel group emits correctly from plane 0.
